ex_mem_stage_reg: RTL and testbench

//  EX/MEM pipeline register: the consuming end of the EX-stage result bundle (exmem_in side).

---
 rtl/ex_mem_stage_reg.sv | 100 ++++++++++
 tb/tb_ex_mem_stage_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register with trap/alignment checks, store lane
// formatting and the LL/SC link state.
module ex_mem_stage_reg #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ClearLink,
  input  logic        Trap,
  input  logic        TrapCond,
  input  logic        LLSC,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        ExcOv,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [4:0]  RegDstOut,
  output logic        M_MemRead,
  output logic        M_MemWrite,
  output logic        M_MemHalf,
  output logic        M_MemByte,
  output logic        M_MemSignExtend,
  output logic        M_RegWrite,
  output logic        M_MemtoReg,
  output logic [3:0]  M_ByteEn,
  output logic [31:0] M_ALUResult,
  output logic [31:0] M_StoreData,
  output logic [4:0]  M_RegDst,
  output logic        M_ExcTrap,
  output logic        M_ExcOv,
  output logic        M_ExcAdEL,
  output logic        M_ExcAdES,
  output logic        LinkValid
);
  logic        r_link;
  logic [29:0] r_link_addr;
  logic        w_mis, w_trap, w_adel, w_ades, w_exc, w_ll, w_sc, w_link_eff, w_sc_ok, w_wr, w_cap, w_set_link;
  logic [3:0]  w_lanes, w_be;
  logic [31:0] w_sd, w_alu;
  always_comb begin
    w_mis      = MemByte ? 1'b0 : MemHalf ? ALUResult[0] : |ALUResult[1:0];
    w_trap     = Trap & (ALUResult[0] == TrapCond);
    w_adel     = MemRead & w_mis;
    w_ades     = MemWrite & w_mis;
    w_exc      = w_trap | ExcOv | w_adel | w_ades;
    w_ll       = LLSC & MemRead;
    w_sc       = LLSC & MemWrite;
    // ClearLink acts before SC evaluation, so a same-cycle SC sees the link gone
    w_link_eff = r_link & ~ClearLink;
    w_sc_ok    = w_link_eff & (ALUResult[31:2] == r_link_addr) & ~w_mis;
    w_wr       = MemWrite & ~w_exc & (~w_sc | w_sc_ok);
    w_lanes    = MemByte ? 4'b0001 << ALUResult[1:0] : MemHalf ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_be       = ~w_wr ? 4'b0000 : BIG_ENDIAN ? {w_lanes[0], w_lanes[1], w_lanes[2], w_lanes[3]} : w_lanes;
    w_sd       = MemByte ? {4{ReadData2[7:0]}} : MemHalf ? {2{ReadData2[15:0]}} : ReadData2;
    w_alu      = w_sc ? {31'b0, w_sc_ok} : ALUResult;
    w_cap      = ~Flush & ~Stall;
    w_set_link = w_cap & w_ll & ~w_exc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link      <= 1'b0;
      r_link_addr <= '0;
      {M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_RegWrite, M_MemtoReg} <= '0;
      {M_ByteEn, M_ALUResult, M_StoreData, M_RegDst} <= '0;
      {M_ExcTrap, M_ExcOv, M_ExcAdEL, M_ExcAdES} <= '0;
    end else begin
      r_link <= w_set_link ? 1'b1 : (w_cap & w_sc) ? 1'b0 : w_link_eff;
      if (w_set_link) r_link_addr <= ALUResult[31:2];
      if (Flush) begin
        {M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_RegWrite, M_MemtoReg} <= '0;
        {M_ByteEn, M_ALUResult, M_StoreData, M_RegDst} <= '0;
        {M_ExcTrap, M_ExcOv, M_ExcAdEL, M_ExcAdES} <= '0;
      end else if (!Stall) begin
        M_MemRead       <= MemRead & ~w_exc;
        M_MemWrite      <= w_wr;
        M_MemHalf       <= MemHalf;
        M_MemByte       <= MemByte;
        M_MemSignExtend <= MemSignExtend;
        M_RegWrite      <= RegWrite & ~w_exc;
        M_MemtoReg      <= MemtoReg;
        M_ByteEn        <= w_be;
        M_ALUResult     <= w_alu;
        M_StoreData     <= w_sd;
        M_RegDst        <= RegDstOut;
        M_ExcTrap       <= w_trap;
        M_ExcOv         <= ExcOv;
        M_ExcAdEL       <= w_adel;
        M_ExcAdES       <= w_ades;
      end
    end
  end
  assign LinkValid = r_link;
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: directed vectors with a queue-based scoreboard and a decoupled monitor.
module tb_ex_mem_stage_reg;
  logic clk = 1'b0, rst_n = 1'b0;
  logic Stall, Flush, ClearLink, Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte;
  logic MemSignExtend, RegWrite, MemtoReg, ExcOv;
  logic [31:0] ALUResult, ReadData2;
  logic [4:0]  RegDstOut;
  logic M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_RegWrite, M_MemtoReg;
  logic [3:0]  M_ByteEn;
  logic [31:0] M_ALUResult, M_StoreData;
  logic [4:0]  M_RegDst;
  logic M_ExcTrap, M_ExcOv, M_ExcAdEL, M_ExcAdES, LinkValid;
  logic [84:0] dut_out;
  typedef struct {string n; logic [84:0] v;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .ClearLink(ClearLink),
    .Trap(Trap), .TrapCond(TrapCond), .LLSC(LLSC), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemHalf(MemHalf), .MemByte(MemByte), .MemSignExtend(MemSignExtend), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ExcOv(ExcOv), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .RegDstOut(RegDstOut), .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemHalf(M_MemHalf),
    .M_MemByte(M_MemByte), .M_MemSignExtend(M_MemSignExtend), .M_RegWrite(M_RegWrite),
    .M_MemtoReg(M_MemtoReg), .M_ByteEn(M_ByteEn), .M_ALUResult(M_ALUResult),
    .M_StoreData(M_StoreData), .M_RegDst(M_RegDst), .M_ExcTrap(M_ExcTrap), .M_ExcOv(M_ExcOv),
    .M_ExcAdEL(M_ExcAdEL), .M_ExcAdES(M_ExcAdES), .LinkValid(LinkValid)
  );

  assign dut_out = {M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_RegWrite,
                    M_MemtoReg, M_ByteEn, M_ALUResult, M_StoreData, M_RegDst,
                    M_ExcTrap, M_ExcOv, M_ExcAdEL, M_ExcAdES, LinkValid};

  // ctl = {rd,wr,half,byte,sx,rw,m2r}; exc = {trap,ov,adel,ades}
  function automatic logic [84:0] ev(input logic [6:0] ctl, input logic [3:0] be,
                                     input logic [31:0] alu, input logic [31:0] sd,
                                     input logic [4:0] rd, input logic [3:0] exc, input logic lnk);
    return {ctl, be, alu, sd, rd, exc, lnk};
  endfunction

  task automatic clr();
    {Stall, Flush, ClearLink, Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte} = '0;
    {MemSignExtend, RegWrite, MemtoReg, ExcOv} = '0;
    ALUResult = '0; ReadData2 = '0; RegDstOut = '0;
  endtask

  task automatic cyc(input string n, input logic [84:0] v);
    exp_t e;
    e.n = n; e.v = v;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_now(input string n, input logic [84:0] v);
    checks++;
    if (dut_out !== v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, dut_out, v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (dut_out !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.n, dut_out, e.v);
        end
      end
    end
  end

  initial begin : stim
    clr();
    MemWrite = 1; ALUResult = 32'h1004; ReadData2 = 32'hAABBCCDD;
    repeat (2) @(negedge clk);
    chk_now("reset_state", '0);
    rst_n = 1'b1;
    clr(); MemWrite = 1; ALUResult = 32'h1004; ReadData2 = 32'hAABBCCDD;
    cyc("word_store", ev(7'b0100000, 4'b1111, 32'h1004, 32'hAABBCCDD, 0, 0, 0));
    clr(); MemWrite = 1; MemByte = 1; ALUResult = 32'h1003; ReadData2 = 32'h12;
    cyc("byte_store", ev(7'b0101000, 4'b0001, 32'h1003, 32'h12121212, 0, 0, 0));
    clr(); MemRead = 1; MemHalf = 1; MemSignExtend = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h1001; RegDstOut = 5;
    cyc("half_load_adel", ev(7'b0010101, 0, 32'h1001, 0, 5, 4'b0010, 0));
    clr(); Trap = 1; TrapCond = 1; ALUResult = 32'h1;
    cyc("trap_taken", ev(0, 0, 32'h1, 0, 0, 4'b1000, 0));
    clr(); Trap = 1; TrapCond = 1; ALUResult = 32'h2;
    cyc("trap_not_taken", ev(0, 0, 32'h2, 0, 0, 0, 0));
    clr(); MemWrite = 1; MemHalf = 1; ALUResult = 32'h1002; ReadData2 = 32'h5678;
    cyc("half_store", ev(7'b0110000, 4'b0011, 32'h1002, 32'h56785678, 0, 0, 0));
    clr(); ExcOv = 1; RegWrite = 1; ALUResult = 32'h7FFFFFFF; RegDstOut = 3;
    cyc("overflow", ev(0, 0, 32'h7FFFFFFF, 0, 3, 4'b0100, 0));
    clr(); MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h100; RegDstOut = 7;
    cyc("word_load", ev(7'b1000011, 0, 32'h100, 0, 7, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h2000; RegDstOut = 8;
    cyc("ll_2000", ev(7'b1000011, 0, 32'h2000, 0, 8, 0, 1));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h2000; ReadData2 = 32'hCAFE; RegDstOut = 9;
    cyc("sc_hit", ev(7'b0100010, 4'b1111, 32'h1, 32'hCAFE, 9, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h2000; RegDstOut = 8;
    cyc("ll_2000_again", ev(7'b1000011, 0, 32'h2000, 0, 8, 0, 1));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h2004; ReadData2 = 32'hCAFE; RegDstOut = 9;
    cyc("sc_addr_miss", ev(7'b0000010, 0, 32'h0, 32'hCAFE, 9, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h3000; RegDstOut = 8;
    cyc("ll_3000", ev(7'b1000011, 0, 32'h3000, 0, 8, 0, 1));
    clr(); ClearLink = 1;
    cyc("clearlink_pulse", ev(0, 0, 0, 0, 0, 0, 0));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h3000; ReadData2 = 32'hCAFE; RegDstOut = 9;
    cyc("sc_after_clear", ev(7'b0000010, 0, 32'h0, 32'hCAFE, 9, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h3000; RegDstOut = 8;
    cyc("ll_3000_b", ev(7'b1000011, 0, 32'h3000, 0, 8, 0, 1));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h3000; ReadData2 = 32'hCAFE; RegDstOut = 9; ClearLink = 1;
    cyc("sc_with_clear", ev(7'b0000010, 0, 32'h0, 32'hCAFE, 9, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h3000; RegDstOut = 8; ClearLink = 1;
    cyc("ll_with_clear", ev(7'b1000011, 0, 32'h3000, 0, 8, 0, 1));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h3000; ReadData2 = 32'hCAFE; RegDstOut = 9;
    cyc("sc_after_ll_clear", ev(7'b0100010, 4'b1111, 32'h1, 32'hCAFE, 9, 0, 0));
    clr(); MemRead = 1; LLSC = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h4000; RegDstOut = 10;
    cyc("ll_4000", ev(7'b1000011, 0, 32'h4000, 0, 10, 0, 1));
    clr(); MemWrite = 1; LLSC = 1; RegWrite = 1; ALUResult = 32'h4000; ReadData2 = 32'h77; Flush = 1;
    cyc("flush_keeps_link", ev(0, 0, 0, 0, 0, 0, 1));
    clr(); MemWrite = 1; ALUResult = 32'h1004; ReadData2 = 32'hAABBCCDD; RegDstOut = 4;
    cyc("store_before_stall", ev(7'b0100000, 4'b1111, 32'h1004, 32'hAABBCCDD, 4, 0, 1));
    clr(); Stall = 1; MemRead = 1; RegWrite = 1; ALUResult = 32'h55; RegDstOut = 1;
    cyc("stall_1", ev(7'b0100000, 4'b1111, 32'h1004, 32'hAABBCCDD, 4, 0, 1));
    ClearLink = 1; ALUResult = 32'h66;
    cyc("stall_2_clearlink", ev(7'b0100000, 4'b1111, 32'h1004, 32'hAABBCCDD, 4, 0, 0));
    ClearLink = 0; Trap = 1; TrapCond = 0; ALUResult = 32'h0;
    cyc("stall_3", ev(7'b0100000, 4'b1111, 32'h1004, 32'hAABBCCDD, 4, 0, 0));
    clr(); Stall = 1; Flush = 1; MemWrite = 1; ALUResult = 32'h8; ReadData2 = 32'h99;
    cyc("stall_flush", ev(0, 0, 0, 0, 0, 0, 0));
    clr(); MemRead = 1; RegWrite = 1; MemtoReg = 1; ALUResult = 32'h200; RegDstOut = 12;
    cyc("load_before_reset", ev(7'b1000011, 0, 32'h200, 0, 12, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk_now("async_reset", '0);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
